// File: rtl/conv1x1_acc_stream.sv
// conv1x1_acc_stream: streaming 1x1 convolution. Each accepted beat adds one
// GROUP_IN-wide dot product per output channel into a per-channel accumulator.
// After G beats (G latched on the first beat) the sums are presented on
// conv_out with a valid/ready handshake.
module conv1x1_acc_stream #(
    parameter int GROUP_IN   = 16,
    parameter int OUT_CH     = 4,
    parameter int BW         = 8,
    parameter int MAX_GROUPS = 16,
    parameter int BW_ACC     = 2*BW + $clog2(GROUP_IN*MAX_GROUPS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [$clog2(MAX_GROUPS):0]     cfg_groups,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [GROUP_IN*BW-1:0]          feature,
    input  logic [OUT_CH*GROUP_IN*BW-1:0]   weight,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [OUT_CH*BW_ACC-1:0]        conv_out,
    output logic                            busy
);

    localparam int CW = $clog2(MAX_GROUPS) + 1;
    localparam int PW = 2*BW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACC,
        S_OUT
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [CW-1:0]             r_count;
    logic [CW-1:0]             r_groups;
    logic [CW-1:0]             w_cfg_clamped;
    logic signed [BW_ACC-1:0]  r_acc      [OUT_CH];
    logic signed [BW_ACC-1:0]  w_beat_sum [OUT_CH];
    logic signed [BW_ACC-1:0]  w_acc_next [OUT_CH];
    logic [OUT_CH*BW_ACC-1:0]  w_acc_next_flat;
    logic [OUT_CH*BW_ACC-1:0]  r_conv_out;
    logic [BW-1:0]             w_f;
    logic [BW-1:0]             w_w;
    logic [PW-1:0]             w_prod;
    logic                      w_accept;
    logic                      w_last;

    assign w_accept = in_valid & in_ready;
    assign conv_out = r_conv_out;

    // Dot product of the current beat for every output channel.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch or
        // loop, so no path can leave it unassigned and infer a latch.
        w_f    = '0;
        w_w    = '0;
        w_prod = '0;
        for (int o = 0; o < OUT_CH; o++) begin
            w_beat_sum[o] = '0;
            for (int i = 0; i < GROUP_IN; i++) begin
                w_f    = feature[(GROUP_IN-1-i)*BW +: BW];
                w_w    = weight[(OUT_CH*GROUP_IN-1-(o*GROUP_IN+i))*BW +: BW];
                // Low PW bits of the product of sign-extended operands are the
                // exact signed BW x BW product.
                w_prod = {{BW{w_f[BW-1]}}, w_f} * {{BW{w_w[BW-1]}}, w_w};
                w_beat_sum[o] = w_beat_sum[o]
                              + {{(BW_ACC-PW){w_prod[PW-1]}}, w_prod};
            end
        end
    end

    // Next accumulator value: the first beat overwrites, later beats add.
    always_comb begin
        w_acc_next_flat = '0;
        for (int o = 0; o < OUT_CH; o++) begin
            w_acc_next[o] = (r_state == S_IDLE) ? w_beat_sum[o]
                                                : r_acc[o] + w_beat_sum[o];
            w_acc_next_flat[(OUT_CH-1-o)*BW_ACC +: BW_ACC] = w_acc_next[o];
        end
    end

    // Clamp the requested group count into 1..MAX_GROUPS.
    always_comb begin
        if (cfg_groups == '0) begin
            w_cfg_clamped = CW'(1);
        end else if (cfg_groups > CW'(MAX_GROUPS)) begin
            w_cfg_clamped = CW'(MAX_GROUPS);
        end else begin
            w_cfg_clamped = cfg_groups;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values of the others, independent of block order.
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and handshake decode; in_ready/out_valid/busy depend on state only.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b1;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_last       = (w_cfg_clamped == CW'(1));
                    w_state_next = w_last ? S_OUT : S_ACC;
                end
            end
            S_ACC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_last = (r_count + CW'(1) == r_groups);
                    if (w_last) begin
                        w_state_next = S_OUT;
                    end
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Accumulators, beat counter, latched group count and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count    <= '0;
            r_groups   <= '0;
            r_conv_out <= '0;
            // NOTE: the accumulators are a small flop array, not a RAM, so they
            // are cleared by reset like any other register.
            for (int o = 0; o < OUT_CH; o++) begin
                r_acc[o] <= '0;
            end
        end else begin
            if (w_accept) begin
                for (int o = 0; o < OUT_CH; o++) begin
                    r_acc[o] <= w_acc_next[o];
                end
                if (r_state == S_IDLE) begin
                    r_groups <= w_cfg_clamped;
                    r_count  <= CW'(1);
                end else begin
                    r_count  <= r_count + CW'(1);
                end
                if (w_last) begin
                    r_conv_out <= w_acc_next_flat;
                end
            end else if ((r_state == S_OUT) && out_ready) begin
                r_count <= '0;
            end
        end
    end

endmodule
